mdu_seq: RTL

Multi-cycle sequencer for the RV64M multiply/divide unit in the execute stage. It replaces single-cycle combinational mul/div with an iterative engine: one radix-2 shift-add multiply step or one shift-subtract divide step per cycle. The execute stage issues through a valid/ready handshake and stalls until the result is consumed. It also handles sign pre-/post-processing, W-form width rules, divide-by-zero fast path and pipeline flush.

---
 rtl/mdu_seq.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/mdu_seq.sv
// Iterative RV64M multiply/divide sequencer: one radix-2 shift-add or shift-subtract step per cycle,
// with sign pre/post-processing, W-form handling, divide-by-zero fast path and flush.
package common;
    typedef logic [63:0] word_t;
endpackage

package pipes;
    typedef enum logic [4:0] {
        ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLL, ALU_SRL, ALU_SRA,
        ALU_SLT, ALU_SLTU, ALU_MUL, ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU,
        ALU_MULW, ALU_DIVW, ALU_DIVUW, ALU_REMW, ALU_REMUW
    } alufunc_t;
endpackage

module mdu_seq
    import common::*;
    import pipes::*;
(
    input  logic     clk,
    input  logic     reset,
    input  logic     in_valid,
    output logic     in_ready,
    input  alufunc_t alufunc,
    input  word_t    src1,
    input  word_t    src2,
    input  logic     flush,
    output logic     out_valid,
    input  logic     out_ready,
    output word_t    result,
    output logic     busy
);

    typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

    typedef struct packed {
        logic vld;
        logic mul;
        logic w;
        logic sgn;
        logic rem;
    } dec_t;

    state_t     state, state_n;
    dec_t       dec, dec_q;
    logic       acc_en, dv_zero, fast;
    logic       s1, s2, neg_q, neg_r;
    logic [5:0] cnt;
    word_t      op1, op2, abs1, abs2, dbz_res;
    word_t      a_q, b_q, acc_q, quo_q, res_q;
    word_t      q_fix, r_fix, sel, fix_res;
    logic [31:0] n1w, n2w;
    logic [64:0] rem_sh, diff;

    always_comb begin
        dec = '0;
        case (alufunc)
            ALU_MUL:   begin dec.vld = 1'b1; dec.mul = 1'b1; end
            ALU_DIV:   begin dec.vld = 1'b1; dec.sgn = 1'b1; end
            ALU_DIVU:  begin dec.vld = 1'b1; end
            ALU_REM:   begin dec.vld = 1'b1; dec.sgn = 1'b1; dec.rem = 1'b1; end
            ALU_REMU:  begin dec.vld = 1'b1; dec.rem = 1'b1; end
            ALU_MULW:  begin dec.vld = 1'b1; dec.mul = 1'b1; dec.w = 1'b1; end
            ALU_DIVW:  begin dec.vld = 1'b1; dec.w = 1'b1; dec.sgn = 1'b1; end
            ALU_DIVUW: begin dec.vld = 1'b1; dec.w = 1'b1; end
            ALU_REMW:  begin dec.vld = 1'b1; dec.w = 1'b1; dec.sgn = 1'b1; dec.rem = 1'b1; end
            ALU_REMUW: begin dec.vld = 1'b1; dec.w = 1'b1; dec.rem = 1'b1; end
            default:   ;
        endcase
    end

    // Operand prep: W ops narrow to 32 bits; signed divides work on magnitudes.
    always_comb begin
        op1  = dec.w ? {32'b0, src1[31:0]} : src1;
        op2  = dec.w ? {32'b0, src2[31:0]} : src2;
        s1   = dec.w ? src1[31] : src1[63];
        s2   = dec.w ? src2[31] : src2[63];
        n1w  = -src1[31:0];
        n2w  = -src2[31:0];
        abs1 = op1;
        abs2 = op2;
        if (dec.sgn && s1) abs1 = dec.w ? {32'b0, n1w} : -src1;
        if (dec.sgn && s2) abs2 = dec.w ? {32'b0, n2w} : -src2;
        dv_zero = (op2 == '0);
        if (dec.rem) dbz_res = dec.w ? {{32{src1[31]}}, src1[31:0]} : src1;
        else         dbz_res = '1;
        fast = !dec.vld || (!dec.mul && dv_zero);
    end

    assign acc_en = in_valid & in_ready & ~flush;

    // Divide step: shift next dividend bit into the partial remainder, subtract if it fits.
    assign rem_sh = {acc_q, a_q[63]};
    assign diff   = rem_sh - {1'b0, b_q};

    always_comb begin
        q_fix   = neg_q ? -quo_q : quo_q;
        r_fix   = neg_r ? -acc_q : acc_q;
        sel     = dec_q.mul ? acc_q : (dec_q.rem ? r_fix : q_fix);
        fix_res = dec_q.w ? {{32{sel[31]}}, sel[31:0]} : sel;
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE: if (acc_en) state_n = fast ? DONE : RUN;
            RUN:  if (cnt == 6'd0) state_n = FIX;
            FIX:  state_n = DONE;
            DONE: if (out_ready) state_n = IDLE;
            default: state_n = IDLE;
        endcase
        if (flush) state_n = IDLE;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            dec_q <= '0;
            cnt   <= '0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
            a_q   <= '0;
            b_q   <= '0;
            acc_q <= '0;
            quo_q <= '0;
            res_q <= '0;
        end else if (acc_en) begin
            dec_q <= dec;
            cnt   <= dec.w ? 6'd31 : 6'd63;
            neg_q <= dec.sgn & (s1 ^ s2);
            neg_r <= dec.sgn & s1;
            acc_q <= '0;
            quo_q <= '0;
            if (dec.mul) begin
                a_q <= op1;
                b_q <= op2;
            end else begin
                // W dividends are pre-aligned so the MSB-first step always reads bit 63.
                a_q <= dec.w ? {abs1[31:0], 32'b0} : abs1;
                b_q <= abs2;
            end
            if (!dec.vld)   res_q <= '0;
            else if (fast)  res_q <= dbz_res;
        end else if (state == RUN) begin
            cnt <= cnt - 6'd1;
            a_q <= a_q << 1;
            if (dec_q.mul) begin
                if (b_q[0]) acc_q <= acc_q + a_q;
                b_q <= b_q >> 1;
            end else if (!diff[64]) begin
                acc_q <= diff[63:0];
                quo_q <= {quo_q[62:0], 1'b1};
            end else begin
                acc_q <= rem_sh[63:0];
                quo_q <= {quo_q[62:0], 1'b0};
            end
        end else if (state == FIX) begin
            res_q <= fix_res;
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign result    = res_q;

endmodule
